evolution_scheduler: RTL and testbench



---
 rtl/life_pkg.sv | 22 ++
 rtl/evolution_scheduler_gen_pacer.sv | 37 +++
 rtl/evolution_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_evolution_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-life grid sequencing logic.
package life_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_STEP  = 3'd4,
    S_EDIT  = 3'd5
  } sched_state_t;

  // One-hot cursor moves from the keyboard controller
  localparam logic [3:0] SET_A = 4'b0001;  // x-1
  localparam logic [3:0] SET_W = 4'b0010;  // y-1
  localparam logic [3:0] SET_S = 4'b0100;  // y+1
  localparam logic [3:0] SET_D = 4'b1000;  // x+1

  // Fastest supported speed setting; larger shifts are held at this value
  localparam logic [3:0] SPEED_MAX = 4'd5;

endpackage

// File: rtl/evolution_scheduler_gen_pacer.sv
// Generation pacer: counts clk_in cycles while enabled and emits a one-cycle
// tick once per (P_BASE_PERIOD >> speed) cycles, using the live speed value.
module gen_pacer
  import life_pkg::*;
#(
  parameter int unsigned P_BASE_PERIOD = 25_000_000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] evo_left_shift,
  output logic       tick
);

  localparam logic [31:0] BASE = 32'(P_BASE_PERIOD);

  logic [31:0] count;
  logic [31:0] period;
  logic [3:0]  shift;

  // Shifted period (clamped to at least one cycle) and terminal-count compare
  always_comb begin
    shift  = (evo_left_shift > SPEED_MAX) ? SPEED_MAX : evo_left_shift;
    period = BASE >> shift;
    if (period == '0) period = 32'd1;
    // >= so that a mid-interval speed-up never lets the count run past the limit
    tick = enable && (count >= period - 32'd1);
  end

  // Interval counter; restarts on every tick and whenever pacing is off
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)                count <= '0;
    else if (!enable || tick) count <= '0;
    else                      count <= count + 32'd1;
  end

endmodule

// File: rtl/evolution_scheduler.sv
// Scheduler between the keyboard controller and the grid memory clients:
// arbitrates load/clear/step transactions, paces generations, tracks the
// manual-edit cursor and counts generations.
module evolution_scheduler
  import life_pkg::*;
#(
  parameter int unsigned P_PARAM_N     = 64,
  parameter int unsigned P_PARAM_M     = 64,
  parameter int unsigned P_BASE_PERIOD = 25_000_000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic        manual,
  input  logic [3:0]  setting,
  input  logic        setting_valid,
  input  logic        edit_toggle,
  input  logic [15:0] file_id,
  input  logic [3:0]  evo_left_shift,
  output logic        load_start,
  output logic [15:0] load_id,
  input  logic        load_done,
  output logic        clear_start,
  input  logic        clear_done,
  output logic        step_start,
  input  logic        step_done,
  output logic        edit_we,
  output logic [15:0] cursor_x,
  output logic [15:0] cursor_y,
  output logic [31:0] generation,
  output logic [2:0]  state,
  output logic        busy
);

  localparam logic [15:0] X_MAX = 16'(P_PARAM_N - 1);
  localparam logic [15:0] Y_MAX = 16'(P_PARAM_M - 1);

  sched_state_t cur_state, nxt_state;
  logic start_q, pause_q, clear_q;
  logic pend_start, pend_pause, pend_clear;
  logic take_start, take_pause, take_clear;
  logic [15:0] file_shadow;
  logic [15:0] cx, cy, cx_next, cy_next;
  logic load_req, tick, edit_fire;

  assign load_req  = (file_id != file_shadow);
  assign edit_fire = (cur_state == S_EDIT) && edit_toggle;
  assign state     = cur_state;
  // The shadow is captured on LOAD entry, so it is also the latched load id
  assign load_id   = file_shadow;

  gen_pacer #(.P_BASE_PERIOD(P_BASE_PERIOD)) u_pacer (
    .clk_in         (clk_in),
    .reset          (reset),
    .enable         (cur_state == S_RUN),
    .evo_left_shift (evo_left_shift),
    .tick           (tick)
  );

  // Command edge detection and sticky pending flags
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      start_q    <= 1'b0;
      pause_q    <= 1'b0;
      clear_q    <= 1'b0;
      pend_start <= 1'b0;
      pend_pause <= 1'b0;
      pend_clear <= 1'b0;
    end else begin
      start_q    <= start;
      pause_q    <= pause;
      clear_q    <= clear;
      pend_start <= (pend_start & ~take_start) | (start & ~start_q);
      pend_pause <= (pend_pause & ~take_pause) | (pause & ~pause_q);
      pend_clear <= (pend_clear & ~take_clear) | (clear & ~clear_q);
    end
  end

  // Next-state selection and pending-flag consumption
  always_comb begin
    nxt_state  = cur_state;
    take_start = 1'b0;
    take_pause = 1'b0;
    take_clear = 1'b0;
    unique case (cur_state)
      S_IDLE, S_EDIT: begin
        if (pend_clear) begin
          nxt_state  = S_CLEAR;
          take_clear = 1'b1;
        end else if (load_req) begin
          nxt_state = S_LOAD;
        end else if (pend_pause) begin
          take_pause = 1'b1;
        end else if (pend_start) begin
          nxt_state  = S_RUN;
          take_start = 1'b1;
        end else if (cur_state == S_IDLE && manual) begin
          nxt_state = S_EDIT;
        end else if (cur_state == S_EDIT && !manual) begin
          nxt_state = S_IDLE;
        end
      end
      S_LOAD:  if (load_done)  nxt_state = S_IDLE;
      S_CLEAR: if (clear_done) nxt_state = S_IDLE;
      S_RUN: begin
        if (pend_clear) begin
          nxt_state  = S_CLEAR;
          take_clear = 1'b1;
        end else if (pend_pause) begin
          nxt_state  = S_IDLE;
          take_pause = 1'b1;
        end else begin
          take_start = pend_start;
          if (tick) nxt_state = S_STEP;
        end
      end
      S_STEP: begin
        if (step_done) begin
          if (pend_clear) begin
            nxt_state  = S_CLEAR;
            take_clear = 1'b1;
          end else if (pend_pause) begin
            nxt_state  = S_IDLE;
            take_pause = 1'b1;
          end else begin
            nxt_state = S_RUN;
          end
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // State register, entry pulses, busy flag, file shadow and generation count
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cur_state   <= S_IDLE;
      load_start  <= 1'b0;
      clear_start <= 1'b0;
      step_start  <= 1'b0;
      busy        <= 1'b0;
      file_shadow <= '0;
      generation  <= '0;
    end else begin
      cur_state   <= nxt_state;
      load_start  <= (nxt_state == S_LOAD)  && (cur_state != S_LOAD);
      clear_start <= (nxt_state == S_CLEAR) && (cur_state != S_CLEAR);
      step_start  <= (nxt_state == S_STEP)  && (cur_state != S_STEP);
      busy        <= (nxt_state == S_LOAD) || (nxt_state == S_CLEAR) ||
                     (nxt_state == S_STEP);
      if (nxt_state == S_LOAD && cur_state != S_LOAD) file_shadow <= file_id;
      if (cur_state == S_STEP && step_done)
        generation <= generation + 32'd1;
      else if ((cur_state == S_LOAD && load_done) ||
               (cur_state == S_CLEAR && clear_done))
        generation <= '0;
    end
  end

  // Wrap-around cursor move for the current setting strobe
  always_comb begin
    cx_next = cx;
    cy_next = cy;
    if (cur_state == S_EDIT && setting_valid) begin
      case (setting)
        SET_A:   cx_next = (cx == '0)    ? Y_MAX - Y_MAX + X_MAX : cx - 16'd1;
        SET_D:   cx_next = (cx == X_MAX) ? '0 : cx + 16'd1;
        SET_W:   cy_next = (cy == '0)    ? Y_MAX : cy - 16'd1;
        SET_S:   cy_next = (cy == Y_MAX) ? '0 : cy + 16'd1;
        default: ;
      endcase
    end
  end

  // Cursor tracking and edit write strobe
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cx       <= '0;
      cy       <= '0;
      cursor_x <= '0;
      cursor_y <= '0;
      edit_we  <= 1'b0;
    end else begin
      cx      <= cx_next;
      cy      <= cy_next;
      edit_we <= edit_fire;
      // cx/cy track the true cursor; the outputs hold the pre-move position for
      // the edit_we cycle when a toggle coincides with a move, then catch up.
      cursor_x <= edit_fire ? cx : cx_next;
      cursor_y <= edit_fire ? cy : cy_next;
    end
  end

endmodule

// File: tb/tb_evolution_scheduler.sv
// Scoreboard bench for evolution_scheduler: stimulus pushes the expected
// start-pulse/edit events, a negedge monitor pops and compares them.
module tb_evolution_scheduler;

  localparam int K_LOAD  = 0;
  localparam int K_CLEAR = 1;
  localparam int K_STEP  = 2;
  localparam int K_EDIT  = 3;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, pause = 1'b0, clear = 1'b0, manual = 1'b0;
  logic [3:0]  setting = 4'b0000;
  logic        setting_valid = 1'b0, edit_toggle = 1'b0;
  logic [15:0] file_id = 16'd3;
  logic [3:0]  evo_left_shift = 4'd2;
  logic        load_done = 1'b0, clear_done = 1'b0, step_done = 1'b0;
  logic        load_start, clear_start, step_start, edit_we, busy;
  logic [15:0] load_id, cursor_x, cursor_y;
  logic [31:0] generation;
  logic [2:0]  state;

  ev_t q[$];
  int  total = 0;
  int  bad = 0;

  evolution_scheduler #(
    .P_PARAM_N(8),
    .P_PARAM_M(8),
    .P_BASE_PERIOD(16)
  ) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .pause(pause),
    .clear(clear), .manual(manual), .setting(setting),
    .setting_valid(setting_valid), .edit_toggle(edit_toggle),
    .file_id(file_id), .evo_left_shift(evo_left_shift),
    .load_start(load_start), .load_id(load_id), .load_done(load_done),
    .clear_start(clear_start), .clear_done(clear_done),
    .step_start(step_start), .step_done(step_done), .edit_we(edit_we),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .generation(generation),
    .state(state), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b;
    q.push_back(e);
  endtask

  task automatic sb_check(input int kind, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d expected none", kind, a, b);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.a !== a || e.b !== b) begin
        bad++;
        $display("FAIL event: got kind=%0d a=%0d b=%0d expected kind=%0d a=%0d b=%0d",
                 kind, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  // Monitor: every strobe the DUT presents is matched against the queue
  always @(negedge clk_in) begin
    if (!reset) begin
      if (load_start)  sb_check(K_LOAD, 32'(load_id), 32'(state));
      if (clear_start) sb_check(K_CLEAR, generation, 32'(state));
      if (step_start)  sb_check(K_STEP, generation, 32'(state));
      if (edit_we)     sb_check(K_EDIT, 32'(cursor_x), 32'(cursor_y));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int n = 0;
    while (state != s && n < budget) begin
      cyc(1);
      n++;
    end
    chk(nm, 32'(state), 32'(s));
  endtask

  task automatic cycles_to_step(input int exp, input string nm);
    int n = 0;
    while (state != 3'd4 && n < 50) begin
      cyc(1);
      n++;
    end
    chk(nm, n, exp);
  endtask

  task automatic pulse_step_done();
    step_done = 1'b1;
    cyc(1);
    step_done = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk("rst_state", 32'(state), 0);
    chk("rst_gen", generation, 0);
    chk("rst_load_id", 32'(load_id), 0);
    chk("rst_cursor", {cursor_x, cursor_y}, 0);
    chk("rst_busy", 32'(busy), 0);

    // Load of file 3 right after reset
    push(K_LOAD, 3, 1);
    reset = 1'b0;
    wait_state(3'd1, 5, "load_enter");
    chk("load_busy", 32'(busy), 1);
    cyc(2);
    load_done = 1'b1;
    cyc(1);
    load_done = 1'b0;
    chk("load_exit", 32'(state), 0);
    chk("load_gen", generation, 0);

    // Run: period 16>>2 = 4 cycles, five generations, pause lands during step 5
    for (int i = 0; i < 5; i++) push(K_STEP, i, 4);
    start = 1'b1;
    wait_state(3'd3, 5, "run_enter");
    for (int i = 0; i < 5; i++) begin
      wait_state(3'd4, 30, "step_enter");
      if (i == 4) pause = 1'b1;
      cyc(2);
      pulse_step_done();
      if (i < 4) cycles_to_step(4, "step_interval");
    end
    chk("pause_state", 32'(state), 0);
    chk("gen_after_5", generation, 5);
    cyc(20);
    chk("pause_no_restart", 32'(state), 0);
    start = 1'b0;
    pause = 1'b0;
    cyc(3);

    // Clear and pause rising together while running
    push(K_CLEAR, 5, 2);
    start = 1'b1;
    wait_state(3'd3, 5, "run2_enter");
    clear = 1'b1;
    pause = 1'b1;
    wait_state(3'd2, 5, "clear_enter");
    cyc(2);
    clear_done = 1'b1;
    cyc(1);
    clear_done = 1'b0;
    chk("clear_exit", 32'(state), 0);
    chk("clear_gen", generation, 0);
    start = 1'b0; clear = 1'b0; pause = 1'b0;
    cyc(3);

    // Manual edit on an 8x8 grid
    manual = 1'b1;
    wait_state(3'd5, 5, "edit_enter");
    setting = 4'b0001; setting_valid = 1'b1;
    cyc(1);
    setting_valid = 1'b0;
    chk("cursor_x_wrap_lo", 32'(cursor_x), 7);
    setting = 4'b1000; setting_valid = 1'b1;
    cyc(1);
    setting_valid = 1'b0;
    chk("cursor_x_wrap_hi", 32'(cursor_x), 0);
    push(K_EDIT, 0, 0);
    edit_toggle = 1'b1;
    cyc(1);
    edit_toggle = 1'b0;
    // Toggle coinciding with y+1 must use the pre-move cursor
    push(K_EDIT, 0, 0);
    setting = 4'b0100; setting_valid = 1'b1; edit_toggle = 1'b1;
    cyc(1);
    setting_valid = 1'b0; edit_toggle = 1'b0;
    cyc(1);
    chk("cursor_y_after_move", 32'(cursor_y), 1);
    setting = 4'b0010; setting_valid = 1'b1;
    cyc(2);
    setting_valid = 1'b0;
    chk("cursor_y_wrap_lo", 32'(cursor_y), 7);
    manual = 1'b0;
    wait_state(3'd0, 5, "edit_exit");

    // Reset in the middle of a load
    push(K_LOAD, 9, 1);
    file_id = 16'd9;
    wait_state(3'd1, 5, "load2_enter");
    cyc(1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_state", 32'(state), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_load_id", 32'(load_id), 0);
    file_id = 16'd0;
    cyc(2);
    reset = 1'b0;
    load_done = 1'b1;
    cyc(1);
    load_done = 1'b0;
    cyc(3);
    chk("stray_done_state", 32'(state), 0);
    chk("stray_done_gen", generation, 0);

    // Fastest speed: 16>>5 = 0 is clamped to a one-cycle period
    evo_left_shift = 4'd5;
    push(K_STEP, 0, 4);
    push(K_STEP, 1, 4);
    start = 1'b1;
    wait_state(3'd4, 10, "fast_step_enter");
    cyc(1);
    pulse_step_done();
    cycles_to_step(1, "fast_interval");
    pause = 1'b1;
    cyc(2);
    pulse_step_done();
    chk("fast_pause_state", 32'(state), 0);
    chk("fast_gen", generation, 2);
    start = 1'b0; pause = 1'b0;
    cyc(10);

    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
